// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - default widths and the grouped config record for the PWM channel
package pwm_pkg;

  localparam int PWM_CNT_W  = 16;
  localparam int PWM_TRIG_W = 3;

  // Field-for-field mirror of the shadowed config that reg_map presents to the channel.
  typedef struct packed {
    logic [PWM_CNT_W-1:0]  period;
    logic [PWM_CNT_W-1:0]  phase;
    logic [PWM_CNT_W-1:0]  duty_cycle;
    logic [PWM_TRIG_W-1:0] trig_count;
    logic                  enable;
    logic                  invert;
    logic                  initial_val;
    logic                  start;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel_if.sv
// rtl/pwm_channel_if.sv - config/status bundle between reg_map (master) and the PWM channel (slave)
interface pwm_channel_if #(
  parameter int CNT_W  = pwm_pkg::PWM_CNT_W,
  parameter int TRIG_W = pwm_pkg::PWM_TRIG_W
);

  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  phase;
  logic [CNT_W-1:0]  duty_cycle;
  logic [TRIG_W-1:0] trig_count;
  logic              enable;
  logic              invert;
  logic              initial_val;
  logic              start;

  logic              update;
  logic              pwm_out;
  logic              trig_out;
  logic [CNT_W-1:0]  count;

  modport master (
    output period, phase, duty_cycle, trig_count, enable, invert, initial_val, start,
    input  update, pwm_out, trig_out, count
  );

  modport slave (
    input  period, phase, duty_cycle, trig_count, enable, invert, initial_val, start,
    output update, pwm_out, trig_out, count
  );

endinterface

// File: rtl/pwm_period_counter.sv
// rtl/pwm_period_counter.sv - period counter, wrap detect, registered update pulse and period index
module pwm_period_counter #(
  parameter int CNT_W  = 16,
  parameter int TRIG_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_period,
  input  logic [TRIG_W-1:0] i_trig_count,
  output logic [CNT_W-1:0]  o_count,
  output logic [TRIG_W-1:0] o_idx,
  output logic              o_update
);

  logic [CNT_W-1:0]  r_count;
  logic [TRIG_W-1:0] r_idx;
  logic              r_update;

  logic [CNT_W-1:0]  w_count_nxt;
  logic [TRIG_W-1:0] w_idx_nxt;
  logic              w_update_nxt;
  logic              w_short;
  logic              w_last;

  always_comb begin
    w_count_nxt = '0;
    w_idx_nxt   = '0;
    w_short     = (i_period <= CNT_W'(1));
    // >= rather than == so a count stranded above a shrunken period still wraps promptly
    w_last      = w_short || (r_count >= i_period - CNT_W'(1));
    if (i_start) begin
      if (w_last) begin
        w_count_nxt = '0;
        w_idx_nxt   = (r_idx >= i_trig_count) ? '0 : r_idx + TRIG_W'(1);
      end else begin
        w_count_nxt = r_count + CNT_W'(1);
        w_idx_nxt   = r_idx;
      end
    end
    // Registered, so it is computed from the count the next cycle will show.
    w_update_nxt = i_start && (w_short || (w_count_nxt == i_period - CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_idx    <= '0;
      r_update <= 1'b0;
    end else begin
      r_count  <= w_count_nxt;
      r_idx    <= w_idx_nxt;
      r_update <= w_update_nxt;
    end
  end

  assign o_count  = r_count;
  assign o_idx    = r_idx;
  assign o_update = r_update;

endmodule

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - PWM channel top: active-window compare, registered pwm_out and trig_out
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W  = PWM_CNT_W,
  parameter int TRIG_W = PWM_TRIG_W
) (
  input logic          clk,
  input logic          rst,
  pwm_channel_if.slave bus
);

  logic [CNT_W-1:0]  w_count;
  logic [TRIG_W-1:0] w_idx;
  logic              w_update;

  logic [CNT_W:0]    w_dist;
  logic              w_phase_ok;
  logic              w_active;
  logic              w_trig_hit;

  logic              r_pwm;
  logic              r_trig;

  pwm_period_counter #(
    .CNT_W  (CNT_W),
    .TRIG_W (TRIG_W)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .i_start      (bus.start),
    .i_period     (bus.period),
    .i_trig_count (bus.trig_count),
    .o_count      (w_count),
    .o_idx        (w_idx),
    .o_update     (w_update)
  );

  // Distance from the window start, folded through the wrap so windows can straddle count 0.
  always_comb begin
    w_phase_ok = (bus.phase < bus.period);
    if (w_count >= bus.phase) begin
      w_dist = {1'b0, w_count} - {1'b0, bus.phase};
    end else begin
      w_dist = {1'b0, w_count} + {1'b0, bus.period} - {1'b0, bus.phase};
    end
    w_active   = w_phase_ok && (bus.period > CNT_W'(1)) && (w_dist < {1'b0, bus.duty_cycle});
    w_trig_hit = bus.start && bus.enable && w_phase_ok &&
                 (w_count == bus.phase) && (w_idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm  <= 1'b0;
      r_trig <= 1'b0;
    end else begin
      r_pwm  <= (!bus.enable || !bus.start) ? bus.initial_val : (w_active ^ bus.invert);
      r_trig <= w_trig_hit;
    end
  end

  assign bus.count    = w_count;
  assign bus.update   = w_update;
  assign bus.pwm_out  = r_pwm;
  assign bus.trig_out = r_trig;

endmodule

// File: tb/tb_pwm_channel.sv
// tb/tb_pwm_channel.sv - self-checking bench for pwm_channel against a behavioural period model
`timescale 1ns/1ps
module tb_pwm_channel;
  import pwm_pkg::*;

  localparam int CW = 16;
  localparam int TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_channel_if #(.CNT_W(CW), .TRIG_W(TW)) bus ();

  pwm_channel #(.CNT_W(CW), .TRIG_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pwm_cfg_t cfg;
  pwm_cfg_t pend_cfg;
  bit       pend_valid = 1'b0;

  assign bus.period      = cfg.period;
  assign bus.phase       = cfg.phase;
  assign bus.duty_cycle  = cfg.duty_cycle;
  assign bus.trig_count  = cfg.trig_count;
  assign bus.enable      = cfg.enable;
  assign bus.invert      = cfg.invert;
  assign bus.initial_val = cfg.initial_val;
  assign bus.start       = cfg.start;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: what the outputs must show during the current cycle.
  int m_count = 0;
  int m_idx   = 0;
  bit m_upd   = 1'b0;
  bit m_pwm   = 1'b0;
  bit m_trig  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit in_window(int c);
    int p  = int'(cfg.period);
    int ph = int'(cfg.phase);
    if (p <= 1 || ph >= p) return 1'b0;
    return ((c - ph + p) % p) < int'(cfg.duty_cycle);
  endfunction

  task automatic model_edge();
    int c = m_count;
    int x = m_idx;
    int p = int'(cfg.period);
    if (rst) begin
      m_count = 0; m_idx = 0; m_upd = 0; m_pwm = 0; m_trig = 0;
      return;
    end
    m_pwm  = (!cfg.enable || !cfg.start) ? cfg.initial_val : (in_window(c) ^ cfg.invert);
    m_trig = cfg.start && cfg.enable && (int'(cfg.phase) < p) && (c == int'(cfg.phase)) && (x == 0);
    if (!cfg.start) begin
      m_count = 0; m_idx = 0;
    end else if (p <= 1 || c >= p - 1) begin
      m_count = 0;
      m_idx   = (x >= int'(cfg.trig_count)) ? 0 : x + 1;
    end else begin
      m_count = c + 1;
    end
    m_upd = cfg.start && (p <= 1 || m_count == p - 1);
  endtask

  // One clock: model follows the edge, a pending reg_map load lands just after the
  // edge that closes an update cycle, and all outputs are compared on the falling edge.
  task automatic tick();
    bit was_upd = m_upd;
    bit s;
    @(posedge clk);
    model_edge();
    #1;
    if (pend_valid && was_upd && !rst) begin
      s = cfg.start;
      cfg = pend_cfg;
      cfg.start = s;
      pend_valid = 1'b0;
    end
    @(negedge clk);
    chk("count",    32'(bus.count),    32'(m_count));
    chk("update",   32'(bus.update),   32'(m_upd));
    chk("pwm_out",  32'(bus.pwm_out),  32'(m_pwm));
    chk("trig_out", 32'(bus.trig_out), 32'(m_trig));
  endtask

  task automatic do_reset();
    pend_valid = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_n(input int n, input int tcnt, output int pw, output int up,
                       output int tr, output int tr_at);
    pw = 0; up = 0; tr = 0; tr_at = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      pw += int'(bus.pwm_out);
      up += int'(bus.update);
      tr += int'(bus.trig_out);
      if (bus.trig_out && int'(bus.count) == tcnt) tr_at++;
    end
  endtask

  task automatic wait_load();
    for (int i = 0; i < 400 && pend_valid; i++) tick();
    chk("load_timeout", 32'(pend_valid), 32'd0);
  endtask

  task automatic set_cfg(input int p, input int ph, input int d, input int tc,
                         input bit en, input bit inv, input bit iv, input bit st);
    cfg.period      = 16'(p);
    cfg.phase       = 16'(ph);
    cfg.duty_cycle  = 16'(d);
    cfg.trig_count  = 3'(tc);
    cfg.enable      = en;
    cfg.invert      = inv;
    cfg.initial_val = iv;
    cfg.start       = st;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pw, up, tr, ta;
    int exp_cnt [6] = '{1, 2, 3, 4, 0, 1};
    int p;

    // 1: basic 3-of-10 waveform, reset state pinned to literals
    set_cfg(10, 0, 3, 0, 1, 0, 0, 1);
    do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count",  32'(bus.count),    32'd0);
    chk("rst_update", 32'(bus.update),   32'd0);
    chk("rst_pwm",    32'(bus.pwm_out),  32'd0);
    chk("rst_trig",   32'(bus.trig_out), 32'd0);
    run_n(1000, 1, pw, up, tr, ta);
    chk("t1_pwm_high", 32'(pw), 32'd300);
    chk("t1_updates",  32'(up), 32'd100);
    chk("t1_trigs",    32'(ta), 32'd100);

    // 2: window crossing the wrap
    set_cfg(10, 8, 4, 0, 1, 0, 0, 1);
    do_reset();
    run_n(1000, 9, pw, up, tr, ta);
    chk("t2_pwm_high",  32'(pw), 32'd400);
    chk("t2_trig_at_8", 32'(ta), 32'd100);
    chk("t2_trigs",     32'(tr), 32'd100);

    // 3: parked output keeps update flowing; then inverted output
    set_cfg(10, 0, 3, 0, 0, 0, 1, 1);
    do_reset();
    run_n(100, 0, pw, up, tr, ta);
    chk("t3_parked_high", 32'(pw), 32'd100);
    chk("t3_updates",     32'(up), 32'd10);
    pend_cfg = cfg;
    pend_cfg.enable = 1'b1;
    pend_cfg.invert = 1'b1;
    pend_valid = 1'b1;
    wait_load();
    run_n(100, 0, pw, up, tr, ta);
    chk("t3_inv_high", 32'(pw), 32'd70);

    // 4: trigger decimation
    set_cfg(8, 2, 1, 2, 1, 0, 0, 1);
    do_reset();
    run_n(72, 3, pw, up, tr, ta);
    chk("t4_trigs",    32'(tr), 32'd3);
    chk("t4_trig_at2", 32'(ta), 32'd3);

    // 5: degenerate period then a clean load on update
    set_cfg(0, 0, 0, 0, 1, 0, 0, 1);
    do_reset();
    run_n(5, 0, pw, up, tr, ta);
    chk("t5_updates", 32'(up), 32'd5);
    chk("t5_pwm",     32'(pw), 32'd0);
    pend_cfg = cfg;
    pend_cfg.period = 16'd5;
    pend_cfg.duty_cycle = 16'd2;
    pend_valid = 1'b1;
    wait_load();
    chk("t5_load_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_seq_count", 32'(bus.count), 32'(exp_cnt[i]));
      if (i == 3) chk("t5_upd_at_4", 32'(bus.update), 32'd1);
    end

    // 6: reset mid-window, then start dropped mid-period
    set_cfg(10, 0, 5, 0, 1, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 50 && m_count != 2; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_count",  32'(bus.count),    32'd0);
    chk("t6_rst_update", 32'(bus.update),   32'd0);
    chk("t6_rst_pwm",    32'(bus.pwm_out),  32'd0);
    chk("t6_rst_trig",   32'(bus.trig_out), 32'd0);
    for (int i = 0; i < 50 && m_count != 4; i++) tick();
    cfg.start = 1'b0;
    cfg.initial_val = 1'b1;
    tick();
    chk("t6_stop_count",  32'(bus.count),   32'd0);
    chk("t6_stop_pwm",    32'(bus.pwm_out), 32'd1);
    chk("t6_stop_update", 32'(bus.update),  32'd0);

    // Random config sequences loaded on update, with start/level toggles and rare resets
    set_cfg(12, 3, 5, 1, 1, 0, 0, 1);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) cfg.start = ~cfg.start;
      if ($urandom_range(0, 99) == 0) begin
        cfg.enable      = 1'($urandom);
        cfg.invert      = 1'($urandom);
        cfg.initial_val = 1'($urandom);
      end
      if (!pend_valid && $urandom_range(0, 3) == 0) begin
        p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 20));
        pend_cfg = cfg;
        pend_cfg.period     = 16'(p);
        pend_cfg.phase      = 16'($urandom_range(0, p + 2));
        pend_cfg.duty_cycle = 16'($urandom_range(0, p + 2));
        pend_cfg.trig_count = 3'($urandom_range(0, 7));
        pend_cfg.enable     = ($urandom_range(0, 4) != 0);
        pend_cfg.invert     = 1'($urandom);
        pend_valid = 1'b1;
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        pend_valid = 1'b0;
      end
      tick();
      rst = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
